// File: rtl/async_fifo_pkg.sv
// Shared constants, pointer type and Gray-code helper for async_fifo.
package async_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 3;
  localparam int unsigned GRAY_MAX_W     = 32;

  typedef logic [DEF_ADDR_WIDTH:0] ptr_t;

  // Operates on a wide vector; callers zero-extend and truncate, which preserves the code.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/async_fifo_mem.sv
// FIFO storage: register array, one synchronous write port, one asynchronous read port.
module async_fifo_mem
  import async_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/async_fifo.sv
// Single-clock first-word-fall-through FIFO with the dual-clock FIFO's port set.
// Define ASYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module async_fifo
  import async_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   wr_gray, rd_gray;
  logic [ADDR_WIDTH:0]   wr_ptr_nxt, rd_ptr_nxt;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Flags come straight from registered Gray pointers; wrap bits differ when full.
  assign empty = (wr_gray == rd_gray);
  assign full  = (wr_gray == {~rd_gray[ADDR_WIDTH -: 2], rd_gray[ADDR_WIDTH-2:0]});

  assign wr_acc     = wr_en && !full;
  assign rd_acc     = rd_en && !empty;
  assign wr_ptr_nxt = wr_ptr + PTR_W'(1);
  assign rd_ptr_nxt = rd_ptr + PTR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      wr_gray <= '0;
    end else if (wr_acc) begin
      wr_ptr  <= wr_ptr_nxt;
      wr_gray <= PTR_W'(bin2gray(GRAY_MAX_W'(wr_ptr_nxt)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      rd_gray <= '0;
    end else if (rd_acc) begin
      rd_ptr  <= rd_ptr_nxt;
      rd_gray <= PTR_W'(bin2gray(GRAY_MAX_W'(rd_ptr_nxt)));
    end
  end

  async_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  // Memory is never reset, so stale contents are masked while empty.
  assign rd_data = empty ? '0 : mem_rdata;

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_async_fifo.sv
// Self-checking bench for async_fifo: directed steps plus random traffic against a queue model.
module tb_async_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          empty;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
  bit            m_ovf;
  bit            m_udf;
`endif

  logic [DW-1:0] q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  string         phase = "init";

  always #5 clk = ~clk;

  async_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty)
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s [%s]: observed %0h expected %0h", tag, phase, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [DW-1:0] head;
    head = (q.size() != 0) ? q[0] : '0;
    check("empty",   32'(empty),   32'(q.size() == 0));
    check("full",    32'(full),    32'(q.size() == DEPTH));
    check("rd_data", 32'(rd_data), 32'(head));
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_udf));
`endif
  endtask

  // Reference behaviour of one clock edge, judged on the occupancy before the edge.
  task automatic model_edge(input logic we, input logic [DW-1:0] wd, input logic re);
    int  occ;
    bit  do_wr, do_rd;
    occ   = q.size();
    do_wr = we && (occ < DEPTH);
    do_rd = re && (occ != 0);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    if (we && occ == DEPTH) m_ovf = 1'b1;
    if (re && occ == 0)     m_udf = 1'b1;
`endif
    if (do_rd) void'(q.pop_front());
    if (do_wr) q.push_back(wd);
  endtask

  task automatic step(input logic we, input logic [DW-1:0] wd, input logic re);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(posedge clk);
    model_edge(we, wd, re);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_outputs();
  endtask

  task automatic model_reset();
    q.delete();
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    m_ovf = 1'b0;
    m_udf = 1'b0;
`endif
  endtask

  initial begin
    logic [DW-1:0] pat [4];
    pat[0] = 8'hA1; pat[1] = 8'hB2; pat[2] = 8'hC3; pat[3] = 8'hD4;
    model_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;

    phase = "reset";
    #12;
    check_outputs();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_rdata", 32'(rd_data), 32'd0);
    #8 rst = 1'b0;
    @(negedge clk);
    check_outputs();

    phase = "basic";
    for (int i = 0; i < 4; i++) step(1'b1, pat[i], 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    check("head_a1", 32'(rd_data), 32'hA1);
    step(1'b0, '0, 1'b1);
    check("head_b2", 32'(rd_data), 32'hB2);
    step(1'b0, '0, 1'b1);
    check("head_c3", 32'(rd_data), 32'hC3);
    while (q.size() != 0) step(1'b0, '0, 1'b1);

    phase = "fill";
    for (int i = 0; i < 8; i++) step(1'b1, DW'(i), 1'b0);
    check("full_after_8", 32'(full), 32'd1);
    step(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("drain_order", 32'(rd_data), 32'(i));
      step(1'b0, '0, 1'b1);
    end
    check("drained_empty", 32'(empty), 32'd1);
    check("drained_rdata", 32'(rd_data), 32'd0);

    phase = "wrap";
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) step(1'b1, DW'(8'h10 * (r + 1) + i), 1'b0);
      check("wrap_full", 32'(full), 32'd1);
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
      check("wrap_empty", 32'(empty), 32'd1);
    end

    phase = "simul_mid";
    for (int i = 0; i < 4; i++) step(1'b1, DW'(8'h40 + i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, DW'(8'h50 + i), 1'b1);
      check("occ_4", 32'(q.size()), 32'd4);
    end
    phase = "simul_full";
    while (q.size() < DEPTH) step(1'b1, DW'($urandom), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    check("simul_full_drop", 32'(full), 32'd0);
    phase = "simul_empty";
    while (q.size() != 0) step(1'b0, '0, 1'b1);
    step(1'b1, 8'h77, 1'b1);
    check("simul_empty_wr", 32'(rd_data), 32'h77);
    step(1'b0, '0, 1'b1);

    phase = "random";
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 99) < 55), DW'($urandom), 1'($urandom_range(0, 99) < 45));

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    phase = "errflags";
    while (q.size() != 0) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    check("underflow_set", 32'(underflow), 32'd1);
    for (int i = 0; i < 9; i++) step(1'b1, DW'(i), 1'b0);
    check("overflow_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
`endif

    phase = "async_rst";
    while (q.size() > 5) step(1'b0, '0, 1'b1);
    while (q.size() < 5) step(1'b1, DW'($urandom), 1'b0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_full",  32'(full),  32'd0);
    check("arst_rdata", 32'(rd_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outputs();
    step(1'b1, 8'h5A, 1'b0);
    check("post_rst_5a", 32'(rd_data), 32'h5A);
    step(1'b0, '0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
